systolic_skew_feeder: RTL and testbench

- Upstream feeder for the NxN systolic PE array.
- Buffers one NxN operand matrix A (row-wise) and one NxN operand matrix B (column-wise) through a valid/ready load port.
- On start, streams both matrices into the array's west and north boundaries with the diagonal skew the array requires, and drives the top-left valid.
- Reports completion after a flush window sized for the array to settle.

---
 rtl/systolic_pkg.sv | 18 +
 rtl/systolic_skew_feeder_if.sv | 30 +++
 rtl/matrix_load_buffer.sv | 34 +++
 rtl/systolic_skew_feeder.sv | 151 +++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// systolic_pkg: types and constants shared by the skew feeder and the PE array.
package systolic_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOADING = 3'd1,
      READY   = 3'd2,
      STREAM  = 3'd3,
      FLUSH   = 3'd4
   } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// systolic_skew_feeder_if: load port, control handshake and array-facing outputs of the feeder.
interface systolic_skew_feeder_if
   import systolic_pkg::*;
#(
   parameter int N          = 2,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic                         load_valid_i;
   logic                         load_ready_o;
   logic [N-1:0][DATA_WIDTH-1:0] load_a_row_i;
   logic [N-1:0][DATA_WIDTH-1:0] load_b_col_i;
   logic                         start_i;
   logic                         busy_o;
   logic                         done_o;
   logic [N-1:0][DATA_WIDTH-1:0] west_o;
   logic [N-1:0][DATA_WIDTH-1:0] north_o;
   logic                         inputs_valid_o;

   modport slave (
      input  load_valid_i, load_a_row_i, load_b_col_i, start_i,
      output load_ready_o, busy_o, done_o, west_o, north_o, inputs_valid_o
   );

   modport master (
      output load_valid_i, load_a_row_i, load_b_col_i, start_i,
      input  load_ready_o, busy_o, done_o, west_o, north_o, inputs_valid_o
   );
endinterface
`default_nettype wire

// File: rtl/matrix_load_buffer.sv
`default_nettype none
// matrix_load_buffer: NxN register file, one whole lane written per beat,
// one element read combinationally per lane.
module matrix_load_buffer
   import systolic_pkg::*;
#(
   parameter int N          = 2,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int IW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic                         clk_i,
   input  logic                         wr_en,
   input  logic [IW-1:0]                wr_lane,
   input  logic [N-1:0][DATA_WIDTH-1:0] wr_data,
   input  logic [N-1:0][IW-1:0]         rd_idx,
   output logic [N-1:0][DATA_WIDTH-1:0] rd_data
);
   // Contents are intentionally not reset; they are only meaningful after a full load.
   logic [N-1:0][N-1:0][DATA_WIDTH-1:0] mem;

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_lane] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int l = 0; l < N; l++) begin
         rd_data[l] = mem[l][rd_idx[l]];
      end
   end
endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// systolic_skew_feeder: buffers A (row-wise) and B (column-wise), then streams
// them diagonally skewed into the west/north edges of an NxN systolic array.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int N          = 2,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   systolic_skew_feeder_if.slave bus
);
   localparam int CW = $clog2(2*N);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   feeder_state_t                state, state_nxt;
   logic [CW-1:0]                beat_cnt, beat_nxt;
   logic [CW-1:0]                step_cnt, step_nxt;
   logic                         load_ready;
   logic                         accept;
   logic [N-1:0]                 lane_ok;
   logic [N-1:0][IW-1:0]         rd_idx;
   logic [N-1:0][DATA_WIDTH-1:0] a_rd, b_rd;
   logic [N-1:0][DATA_WIDTH-1:0] west_q, north_q;
   logic                         valid_q, done_q;

   assign load_ready          = (state == IDLE) || (state == LOADING);
   assign accept              = bus.load_valid_i && load_ready;
   assign bus.load_ready_o    = load_ready;
   assign bus.busy_o          = (state == STREAM) || (state == FLUSH);
   assign bus.done_o          = done_q;
   assign bus.west_o          = west_q;
   assign bus.north_o         = north_q;
   assign bus.inputs_valid_o  = valid_q;

   matrix_load_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_buf_a (
      .clk_i   (clk_i),
      .wr_en   (accept),
      .wr_lane (beat_cnt[IW-1:0]),
      .wr_data (bus.load_a_row_i),
      .rd_idx  (rd_idx),
      .rd_data (a_rd)
   );

   matrix_load_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_buf_b (
      .clk_i   (clk_i),
      .wr_en   (accept),
      .wr_lane (beat_cnt[IW-1:0]),
      .wr_data (bus.load_b_col_i),
      .rd_idx  (rd_idx),
      .rd_data (b_rd)
   );

   // Lane l (row of A, column of B) carries element k-l of its buffer lane, if in range.
   always_comb begin
      lane_ok = '0;
      rd_idx  = '0;
      for (int l = 0; l < N; l++) begin
         if ((int'(step_cnt) >= l) && ((int'(step_cnt) - l) < N)) begin
            lane_ok[l] = 1'b1;
            rd_idx[l]  = IW'(int'(step_cnt) - l);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat_cnt;
      step_nxt  = step_cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (N == 1) begin
                  state_nxt = READY;
               end else begin
                  state_nxt = LOADING;
                  beat_nxt  = CW'(1);
               end
            end
         end
         LOADING: begin
            if (accept) begin
               if (beat_cnt == CW'(N-1)) begin
                  state_nxt = READY;
                  beat_nxt  = '0;
               end else begin
                  beat_nxt = beat_cnt + CW'(1);
               end
            end
         end
         READY: begin
            if (bus.start_i) begin
               state_nxt = STREAM;
               step_nxt  = '0;
            end
         end
         STREAM: begin
            if (step_cnt == CW'(2*N-2)) begin
               state_nxt = FLUSH;
               step_nxt  = '0;
            end else begin
               step_nxt = step_cnt + CW'(1);
            end
         end
         FLUSH: begin
            // The extra count lets the last registered stream step drain before N zero cycles.
            if (step_cnt == CW'(N)) begin
               state_nxt = IDLE;
               step_nxt  = '0;
            end else begin
               step_nxt = step_cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            beat_nxt  = '0;
            step_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state    <= IDLE;
         beat_cnt <= '0;
         step_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_nxt;
         step_cnt <= step_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         west_q  <= '0;
         north_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         for (int l = 0; l < N; l++) begin
            west_q[l]  <= ((state == STREAM) && lane_ok[l]) ? a_rd[l] : '0;
            north_q[l] <= ((state == STREAM) && lane_ok[l]) ? b_rd[l] : '0;
         end
         valid_q <= (state == STREAM) && (step_cnt < CW'(N));
         done_q  <= (state == FLUSH) && (step_cnt == CW'(N));
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// tb_systolic_skew_feeder: directed vectors with hand-computed skewed outputs for N=2.
module tb_systolic_skew_feeder;
   import systolic_pkg::*;

   localparam int N  = 2;
   localparam int DW = 32;

   logic clk_i;
   logic rstn_i;
   int   checks;
   int   failures;

   systolic_skew_feeder_if #(.N(N), .DATA_WIDTH(DW)) bus ();

   systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic load_beat(input int a0, input int a1, input int b0, input int b1);
      bus.load_a_row_i[0] = DW'(a0);
      bus.load_a_row_i[1] = DW'(a1);
      bus.load_b_col_i[0] = DW'(b0);
      bus.load_b_col_i[1] = DW'(b1);
      bus.load_valid_i    = 1'b1;
      tick();
      bus.load_valid_i    = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
   endtask

   task automatic expect_out(input string tag, input int w0, input int w1,
                             input int n0, input int n1, input int v);
      check({tag, ".west0"},  64'(bus.west_o[0]),  64'(w0));
      check({tag, ".west1"},  64'(bus.west_o[1]),  64'(w1));
      check({tag, ".north0"}, 64'(bus.north_o[0]), 64'(n0));
      check({tag, ".north1"}, 64'(bus.north_o[1]), 64'(n1));
      check({tag, ".valid"},  64'(bus.inputs_valid_o), 64'(v));
   endtask

   // Called at stream cycle 3; walks the two flush cycles and the done cycle.
   task automatic expect_tail(input string tag);
      tick();
      expect_out({tag, ".c4"}, 0, 0, 0, 0, 0);
      check({tag, ".c4.done"}, 64'(bus.done_o), 64'd0);
      tick();
      expect_out({tag, ".c5"}, 0, 0, 0, 0, 0);
      check({tag, ".c5.busy"}, 64'(bus.busy_o), 64'd1);
      check({tag, ".c5.done"}, 64'(bus.done_o), 64'd0);
      tick();
      check({tag, ".c6.done"},  64'(bus.done_o), 64'd1);
      check({tag, ".c6.busy"},  64'(bus.busy_o), 64'd0);
      check({tag, ".c6.ready"}, 64'(bus.load_ready_o), 64'd1);
      tick();
      check({tag, ".c7.done"}, 64'(bus.done_o), 64'd0);
   endtask

   initial begin
      int done_seen;
      checks   = 0;
      failures = 0;
      rstn_i   = 1'b0;
      bus.load_valid_i = 1'b0;
      bus.start_i      = 1'b0;
      bus.load_a_row_i = '0;
      bus.load_b_col_i = '0;

      // Reset values with rstn_i held low
      @(negedge clk_i);
      check("rst.ready", 64'(bus.load_ready_o), 64'd1);
      check("rst.busy",  64'(bus.busy_o), 64'd0);
      check("rst.done",  64'(bus.done_o), 64'd0);
      expect_out("rst", 0, 0, 0, 0, 0);
      rstn_i = 1'b1;
      tick();

      // Run 1: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
      load_beat(1, 2, 5, 7);
      check("load1.ready_mid", 64'(bus.load_ready_o), 64'd1);
      load_beat(3, 4, 6, 8);
      check("load1.ready_full", 64'(bus.load_ready_o), 64'd0);
      bus.load_a_row_i = '{default: 32'd99};
      bus.load_b_col_i = '{default: 32'd98};
      bus.load_valid_i = 1'b1;
      tick();
      check("bp.ready.busy", 64'(bus.busy_o), 64'd0);
      pulse_start();
      check("run1.c0.busy", 64'(bus.busy_o), 64'd1);
      expect_out("run1.c0", 0, 0, 0, 0, 0);
      tick();
      expect_out("run1.c1", 1, 0, 5, 0, 1);
      tick();
      expect_out("run1.c2", 2, 3, 7, 6, 1);
      tick();
      expect_out("run1.c3", 0, 4, 0, 8, 0);
      bus.load_valid_i = 1'b0;
      expect_tail("run1");

      // Start without a reload must be ignored
      pulse_start();
      check("norel.busy",  64'(bus.busy_o), 64'd0);
      check("norel.ready", 64'(bus.load_ready_o), 64'd1);

      // Run 2: A=identity, B=all 9s
      load_beat(1, 0, 9, 9);
      load_beat(0, 1, 9, 9);
      pulse_start();
      tick();
      expect_out("run2.c1", 1, 0, 9, 0, 1);
      tick();
      expect_out("run2.c2", 0, 0, 9, 9, 1);
      tick();
      expect_out("run2.c3", 0, 1, 0, 9, 0);
      expect_tail("run2");

      // Reset in STREAM at k=1
      load_beat(1, 2, 5, 7);
      load_beat(3, 4, 6, 8);
      pulse_start();
      tick();
      rstn_i = 1'b0;
      #1;
      expect_out("midrst", 0, 0, 0, 0, 0);
      check("midrst.busy",  64'(bus.busy_o), 64'd0);
      check("midrst.ready", 64'(bus.load_ready_o), 64'd1);
      tick();
      rstn_i = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done_o) done_seen++;
      end
      check("midrst.no_done", 64'(done_seen), 64'd0);
      load_beat(1, 2, 5, 7);
      load_beat(3, 4, 6, 8);
      pulse_start();
      tick();
      expect_out("replay.c1", 1, 0, 5, 0, 1);
      tick();
      expect_out("replay.c2", 2, 3, 7, 6, 1);
      tick();
      expect_out("replay.c3", 0, 4, 0, 8, 0);
      expect_tail("replay");

      // Gap stress: A=[[10,20],[30,40]], B=[[50,60],[70,80]]
      load_beat(10, 20, 50, 70);
      tick();
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      check("gap.early_start.busy",  64'(bus.busy_o), 64'd0);
      check("gap.early_start.ready", 64'(bus.load_ready_o), 64'd1);
      bus.start_i = 1'b1;
      load_beat(30, 40, 60, 80);
      bus.start_i = 1'b0;
      check("gap.coincide.busy",  64'(bus.busy_o), 64'd0);
      check("gap.coincide.ready", 64'(bus.load_ready_o), 64'd0);
      tick();
      check("gap.wait.busy", 64'(bus.busy_o), 64'd0);
      pulse_start();
      check("gap.start.busy", 64'(bus.busy_o), 64'd1);
      tick();
      expect_out("gap.c1", 10, 0, 50, 0, 1);
      tick();
      expect_out("gap.c2", 20, 30, 70, 60, 1);
      tick();
      expect_out("gap.c3", 0, 40, 0, 80, 0);
      expect_tail("gap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
